mo_slave: RTL and testbench

MO_SLAVE -- requirements
Module: mo_slave

---
 rtl/mo_slave.sv | 101 ++++++++++
 tb/tb_mo_slave.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mo_slave.sv
// In-order loopback responder: queues requests and returns each one once its latency timer expires.
// Optional MO_SLAVE_LFSR_LAT_EN adds a pseudo-random 0..7 cycle jitter on top of LAT_CFG.
module mo_slave #(
  parameter int DW    = 32,
  parameter int IDW   = 4,
  parameter int DEPTH = 4,
  parameter int LATW  = 5
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     QVALID,
  output logic                     QREADY,
  input  logic [IDW-1:0]           QID,
  input  logic [DW-1:0]            QDATA,
  output logic                     PVALID,
  input  logic                     PREADY,
  output logic [IDW-1:0]           PID,
  output logic [DW-1:0]            PDATA,
  input  logic [LATW-1:0]          LAT_CFG,
  output logic [$clog2(DEPTH):0]   OUTSTANDING
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]   rptr, wptr;
  logic [AW:0]     count;
  logic            live;
  logic [IDW-1:0]  id_mem   [DEPTH];
  logic [DW-1:0]   data_mem [DEPTH];
  logic [LATW-1:0] tmr      [DEPTH];
  logic            push, pop;
  logic [LATW-1:0] lat_load;

  // live keeps QREADY low until the first edge after reset release
  assign QREADY      = live && (count != FULL);
  assign PVALID      = (count != '0) && (tmr[rptr] == '0);
  assign PID         = PVALID ? id_mem[rptr]   : '0;
  assign PDATA       = PVALID ? data_mem[rptr] : '0;
  assign OUTSTANDING = count;

  assign push = QVALID && QREADY;
  assign pop  = PVALID && PREADY;

`ifdef MO_SLAVE_LFSR_LAT_EN
  logic [15:0]   lfsr;
  logic [LATW:0] lat_sum;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      lfsr <= 16'hACE1;
    end else if (push) begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  assign lat_sum  = {1'b0, LAT_CFG} + (LATW+1)'(lfsr[2:0]);
  assign lat_load = lat_sum[LATW] ? '1 : lat_sum[LATW-1:0];
`else
  assign lat_load = LAT_CFG;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
      live  <= 1'b0;
    end else begin
      live <= 1'b1;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset: outputs are gated by PVALID
  always_ff @(posedge CLK) begin
    if (push) begin
      id_mem[wptr]   <= QID;
      data_mem[wptr] <= QDATA;
    end
  end

  // Every timer counts down regardless of queue position; the head gates issue order
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < DEPTH; i++) tmr[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wptr == AW'(i))) tmr[i] <= lat_load;
        else if (tmr[i] != '0)        tmr[i] <= tmr[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mo_slave.sv
// Bench for mo_slave: cycle-level queue model with due times, directed scenarios and random traffic.
// Builds with or without MO_SLAVE_LFSR_LAT_EN; the model follows the same macro.
module tb_mo_slave;
  localparam int DW = 32, IDW = 4, DEPTH = 4, LATW = 5;
  localparam int LMAX = (1 << LATW) - 1;

  logic CLK = 1'b0, RSTN = 1'b0, QVALID = 1'b0, PREADY = 1'b0;
  logic [IDW-1:0]  QID = '0;
  logic [DW-1:0]   QDATA = '0;
  logic [LATW-1:0] LAT_CFG = '0;
  logic QREADY, PVALID;
  logic [IDW-1:0] PID;
  logic [DW-1:0]  PDATA;
  logic [$clog2(DEPTH):0] OUTSTANDING;

  always #5 CLK = ~CLK;

  mo_slave #(.DW(DW), .IDW(IDW), .DEPTH(DEPTH), .LATW(LATW)) dut (
    .CLK(CLK), .RSTN(RSTN), .QVALID(QVALID), .QREADY(QREADY), .QID(QID), .QDATA(QDATA),
    .PVALID(PVALID), .PREADY(PREADY), .PID(PID), .PDATA(PDATA), .LAT_CFG(LAT_CFG),
    .OUTSTANDING(OUTSTANDING)
  );

  // Model: each entry carries the edge number from which it may be issued
  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    int             due;
  } ent_t;

  ent_t        q[$];
  int          ec = 0;
  bit          started = 1'b0;
  logic [15:0] mlfsr = 16'hACE1;
  int          lat_log[$];
  int          n_chk = 0, n_pass = 0;
  bit          chk_on = 1'b0;

  function automatic bit m_qready();
    return started && (q.size() < DEPTH);
  endfunction

  function automatic bit m_pvalid();
    return (q.size() > 0) && (ec >= q[0].due);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(posedge CLK or negedge RSTN) begin
    bit   acc, pp;
    int   lat, fb;
    ent_t e;
    if (!RSTN) begin
      q.delete();
      ec      = 0;
      started = 1'b0;
      mlfsr   = 16'hACE1;
    end else begin
      acc = QVALID && m_qready();
      pp  = m_pvalid() && PREADY;
      lat = int'(LAT_CFG);
`ifdef MO_SLAVE_LFSR_LAT_EN
      if (acc) begin
        lat = int'(LAT_CFG) + int'(mlfsr % 16'd8);
        if (lat > LMAX) lat = LMAX;
        lat_log.push_back(lat);
        fb    = int'((mlfsr ^ (mlfsr >> 2) ^ (mlfsr >> 3) ^ (mlfsr >> 5)) & 16'd1);
        mlfsr = (mlfsr >> 1) | (16'(fb) << 15);
      end
`endif
      ec++;
      started = 1'b1;
      if (pp) void'(q.pop_front());
      if (acc) begin
        e.id   = QID;
        e.data = QDATA;
        e.due  = ec + lat;
        q.push_back(e);
      end
    end
  end

  always @(negedge CLK) begin
    if (RSTN && chk_on) begin
      chk("qready", QREADY, m_qready());
      chk("pvalid", PVALID, m_pvalid());
      chk("outstanding", OUTSTANDING, q.size());
      if (m_pvalid()) begin
        chk("pid", PID, q[0].id);
        chk("pdata", PDATA, q[0].data);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Entered just after a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [IDW-1:0] id, input logic [DW-1:0] d, input logic [LATW-1:0] lat);
    int b = 0;
    QVALID = 1'b1; QID = id; QDATA = d; LAT_CFG = lat;
    while (!m_qready() && b < 64) begin @(negedge CLK); b++; end
    chk("send_accept", m_qready(), 1);
    @(negedge CLK);
    QVALID = 1'b0; QID = IDW'($urandom); QDATA = $urandom; LAT_CFG = LATW'($urandom);
  endtask

  task automatic wait_pv(output int n);
    n = 0;
    while (!PVALID && n < 100) begin @(negedge CLK); n++; end
    chk("pvalid_seen", PVALID, 1);
  endtask

  task automatic drain();
    QVALID = 1'b0; PREADY = 1'b1;
    cyc(45);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, cnt;
    int exp_lat[4] = '{3, 2, 2, 6};

    repeat (2) @(negedge CLK);
    #2 RSTN = 1'b1;
    #1 chk("rel_qready_low", QREADY, 0);
    chk_on = 1'b1;
    @(negedge CLK);
    chk("first_edge_qready", QREADY, 1);

`ifdef MO_SLAVE_LFSR_LAT_EN
    PREADY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(IDW'(i), $urandom, LATW'(2));
      wait_pv(n);
      chk("lfsr_range", (n >= 2 && n <= 9), 1);
      chk("lfsr_model", n, lat_log[i]);
      if (i < 4) chk("lfsr_literal", n, exp_lat[i]);
      @(negedge CLK);
    end
    drain();
`else
    // single request, latency 3
    PREADY = 1'b1;
    send(IDW'(5), 32'hDEADBEEF, LATW'(3));
    for (int i = 1; i <= 3; i++) begin chk("s1_early", PVALID, 0); @(negedge CLK); end
    chk("s1_pvalid", PVALID, 1);
    chk("s1_pid", PID, 5);
    chk("s1_pdata", PDATA, 32'hDEADBEEF);
    @(negedge CLK);
    chk("s1_one_cycle", PVALID, 0);
    drain();

    // fill to DEPTH with a fifth request waiting
    PREADY = 1'b0;
    for (int i = 0; i < 4; i++) send(IDW'(i + 1), $urandom, LATW'(10));
    chk("fill_qready", QREADY, 0);
    chk("fill_outstanding", OUTSTANDING, 4);
    QVALID = 1'b1; QID = IDW'(9); QDATA = 32'h5555AAAA; LAT_CFG = LATW'(10);
    cyc(3);
    chk("fill_held", OUTSTANDING, 4);
    PREADY = 1'b1;
    n = 0;
    while (!QREADY && n < 40) begin @(negedge CLK); n++; end
    chk("fill_reopen", QREADY, 1);
    chk("fill_after_pop", OUTSTANDING, 3);
    @(negedge CLK);
    drain();

    // backpressure with zero latency
    PREADY = 1'b0;
    send(IDW'(1), 32'h11, LATW'(0));
    send(IDW'(2), 32'h22, LATW'(0));
    send(IDW'(3), 32'h33, LATW'(0));
    for (int i = 0; i < 6; i++) begin
      chk("bp_hold_pv", PVALID, 1);
      chk("bp_hold_pid", PID, 1);
      @(negedge CLK);
    end
    PREADY = 1'b1;
    chk("bp_r1", PID, 1);
    @(negedge CLK);
    chk("bp_r2", PID, 2);
    chk("bp_r2_data", PDATA, 32'h22);
    @(negedge CLK);
    chk("bp_r3", PID, 3);
    @(negedge CLK);
    chk("bp_empty", PVALID, 0);
    drain();

    // long-latency head blocks short-latency follower
    PREADY = 1'b1;
    send(IDW'(10), 32'hA, LATW'(8));
    send(IDW'(11), 32'hB, LATW'(0));
    wait_pv(n);
    chk("order_first", PID, 10);
    @(negedge CLK);
    chk("order_second_pv", PVALID, 1);
    chk("order_second", PID, 11);
    drain();
`endif

    // reset with requests in flight
    PREADY = 1'b0;
    for (int i = 0; i < 3; i++) send(IDW'(i + 4), $urandom, LATW'(10));
    #2 RSTN = 1'b0;
    #1;
    chk("rst_qready", QREADY, 0);
    chk("rst_pvalid", PVALID, 0);
    chk("rst_pid", PID, 0);
    chk("rst_pdata", PDATA, 0);
    chk("rst_outstanding", OUTSTANDING, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #2 RSTN = 1'b1;
    #1 chk("rst_rel_qready", QREADY, 0);
    PREADY = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin @(negedge CLK); if (PVALID) cnt++; end
    chk("rst_no_stale", cnt, 0);
    chk("rst_outstanding_after", OUTSTANDING, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      QVALID  = $urandom_range(0, 1) == 1;
      QID     = IDW'($urandom);
      QDATA   = $urandom;
      LAT_CFG = ($urandom_range(0, 9) == 0) ? LATW'(LMAX) : LATW'($urandom_range(0, 6));
      PREADY  = $urandom_range(0, 3) != 0;
      @(negedge CLK);
    end
    drain();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
